// File: rtl/sprite_pkg.sv
// ---------------------------------------------------------------------------
// sprite_pkg
// Shared definitions for the sprite animation scheduler:
//   - player mode encodings (IDLE / RUN_R)
//   - default frame counts and per-frame hold lengths (in animation ticks)
//   - 12-bit transparent colour keys used by the sprite ROM mux
//   - a helper that tells whether a requested mode code is legal
// ---------------------------------------------------------------------------
package sprite_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'd0,
    MODE_RUN_R = 2'd1
  } ply_mode_t;

  localparam int DEF_TICK_DIV      = 6_000_000;
  localparam int DEF_PLY_IDLE_FRMS = 4;
  localparam int DEF_PLY_RUN_FRMS  = 8;
  localparam int DEF_SLM_FRMS      = 14;
  localparam int DEF_PLY_IDLE_HOLD = 4;
  localparam int DEF_PLY_RUN_HOLD  = 2;
  localparam int DEF_SLM_HOLD      = 2;

  // RGB444 colour treated as "see-through" by the layer mixer
  localparam logic [11:0] PLY_TRANSP_KEY = 12'hF0F;
  localparam logic [11:0] SLM_TRANSP_KEY = 12'h0F0;

  // Codes 2 and 3 are reserved; only IDLE and RUN_R are real modes
  function automatic logic is_legal_mode(input logic [1:0] code);
    return (code == MODE_IDLE) || (code == MODE_RUN_R);
  endfunction

endpackage

// File: rtl/anim_channel.sv
// ---------------------------------------------------------------------------
// anim_channel
// One animation channel: a hold counter that counts animation ticks and a
// frame index that steps once every (hold_last+1) ticks, wrapping after
// frm_last. Limits are run-time inputs so one channel can serve sprites
// whose frame count / hold length depend on a mode.
// Ports:
//   clk        in  1  system clock
//   rst        in  1  synchronous, active-high reset
//   adv        in  1  advance by one animation tick
//   clr        in  1  restart at frame 0 with an empty hold counter
//   frm_last   in  4  last frame index (frame count - 1)
//   hold_last  in  3  last hold count (ticks per frame - 1)
//   frame      out 4  current frame index
// ---------------------------------------------------------------------------
module anim_channel (
  input  logic       clk,
  input  logic       rst,
  input  logic       adv,
  input  logic       clr,
  input  logic [3:0] frm_last,
  input  logic [2:0] hold_last,
  output logic [3:0] frame
);

  logic [2:0] hold_cnt;

  // clr wins over adv so a mode change always restarts cleanly at frame 0.
  // The >= compares keep the channel in range even if limits shrink.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hold_cnt <= 3'd0;
      frame    <= 4'd0;
    end else if (adv) begin
      if (hold_cnt >= hold_last) begin
        hold_cnt <= 3'd0;
        frame    <= (frame >= frm_last) ? 4'd0 : frame + 4'd1;
      end else begin
        hold_cnt <= hold_cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/sprite_anim_sched.sv
// ---------------------------------------------------------------------------
// sprite_anim_sched
// Sequences sprite animation frame selects for the VGA layer mixer: the
// player (idle / run-right) and the slime (idle loop). Frame selects only
// change at the start of vsync so no frame changes mid-image. Player mode
// requests arrive over valid/ready and are applied at the next vsync.
// Optional feature: define SPRITE_ANIM_FREEZE_EN to add the freeze input,
// which holds all frames at boundaries while still applying mode changes.
// Ports:
//   clk            in  1  system clock
//   rst            in  1  synchronous, active-high reset
//   freeze         in  1  hold frames (only with SPRITE_ANIM_FREEZE_EN)
//   vs             in  1  VGA vsync, active low, synchronous to clk
//   mode_req       in  2  requested player mode (0=IDLE, 1=RUN_R)
//   mode_req_valid in  1  request valid
//   mode_req_ready out 1  request accepted when valid & ready
//   ply_mode       out 2  applied player mode
//   ply_frame      out 4  player frame index
//   slm_frame      out 4  slime frame index
//   frame_strobe   out 1  pulse on the cycle the outputs update
//   mode_err       out 1  pulse after an illegal mode code is accepted
// ---------------------------------------------------------------------------
module sprite_anim_sched
  import sprite_pkg::*;
#(
  parameter int TICK_DIV      = DEF_TICK_DIV,
  parameter int PLY_IDLE_FRMS = DEF_PLY_IDLE_FRMS,
  parameter int PLY_RUN_FRMS  = DEF_PLY_RUN_FRMS,
  parameter int SLM_FRMS      = DEF_SLM_FRMS,
  parameter int PLY_IDLE_HOLD = DEF_PLY_IDLE_HOLD,
  parameter int PLY_RUN_HOLD  = DEF_PLY_RUN_HOLD,
  parameter int SLM_HOLD      = DEF_SLM_HOLD
) (
  input  logic       clk,
  input  logic       rst,
`ifdef SPRITE_ANIM_FREEZE_EN
  input  logic       freeze,
`endif
  input  logic       vs,
  input  logic [1:0] mode_req,
  input  logic       mode_req_valid,
  output logic       mode_req_ready,
  output logic [1:0] ply_mode,
  output logic [3:0] ply_frame,
  output logic [3:0] slm_frame,
  output logic       frame_strobe,
  output logic       mode_err
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic              freeze_i;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick_tc;
  logic              tick_pend;
  logic              vs_q;
  logic              boundary;
  logic              adv;
  logic              accept;
  logic              pend_valid;
  ply_mode_t         pend_mode;
  ply_mode_t         state_q;
  ply_mode_t         state_d;
  logic              mode_chg;
  logic [3:0]        ply_frm_last;
  logic [2:0]        ply_hold_last;

`ifdef SPRITE_ANIM_FREEZE_EN
  assign freeze_i = freeze;
`else
  assign freeze_i = 1'b0;
`endif

  assign tick_tc  = (tick_cnt == TICK_W'(TICK_DIV - 1));
  assign boundary = vs_q & ~vs;
  // A terminal tick landing on the boundary cycle is consumed right here
  // rather than left pending for the next frame.
  assign adv      = boundary & (tick_pend | tick_tc) & ~freeze_i;
  assign accept   = mode_req_valid & mode_req_ready;

  assign mode_req_ready = ~pend_valid;
  assign ply_mode       = state_q;

  // Free-running animation tick divider
  always_ff @(posedge clk) begin
    if (rst || tick_tc) tick_cnt <= '0;
    else                tick_cnt <= tick_cnt + TICK_W'(1);
  end

  // Ticks collapse into a single pending flag consumed at each boundary.
  // vs_q resets low so a low vs right after reset is not seen as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_pend    <= 1'b0;
      vs_q         <= 1'b0;
      frame_strobe <= 1'b0;
    end else begin
      vs_q         <= vs;
      frame_strobe <= boundary;
      if (boundary || freeze_i) tick_pend <= 1'b0;
      else if (tick_tc)         tick_pend <= 1'b1;
    end
  end

  // Single-entry request holder. Since ready is ~pend_valid, an accept
  // never coincides with a held request, so a request taken on a boundary
  // cycle simply waits for the following boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_mode  <= MODE_IDLE;
      mode_err   <= 1'b0;
    end else begin
      mode_err <= accept & ~is_legal_mode(mode_req);
      if (accept && is_legal_mode(mode_req)) begin
        pend_valid <= 1'b1;
        pend_mode  <= ply_mode_t'(mode_req);
      end else if (boundary) begin
        pend_valid <= 1'b0;
      end
    end
  end

  // Player mode state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= MODE_IDLE;
    else     state_q <= state_d;
  end

  // Player mode next-state: a held request for a different mode switches
  // at the boundary; a same-mode request is just discarded.
  always_comb begin
    state_d  = state_q;
    mode_chg = 1'b0;
    if (boundary && pend_valid && (pend_mode != state_q)) begin
      state_d  = pend_mode;
      mode_chg = 1'b1;
    end
  end

  assign ply_frm_last  = (state_q == MODE_RUN_R) ? 4'(PLY_RUN_FRMS - 1)
                                                 : 4'(PLY_IDLE_FRMS - 1);
  assign ply_hold_last = (state_q == MODE_RUN_R) ? 3'(PLY_RUN_HOLD - 1)
                                                 : 3'(PLY_IDLE_HOLD - 1);

  anim_channel u_ply_chan (
    .clk       (clk),
    .rst       (rst),
    .adv       (adv & ~mode_chg),
    .clr       (mode_chg),
    .frm_last  (ply_frm_last),
    .hold_last (ply_hold_last),
    .frame     (ply_frame)
  );

  anim_channel u_slm_chan (
    .clk       (clk),
    .rst       (rst),
    .adv       (adv),
    .clr       (1'b0),
    .frm_last  (4'(SLM_FRMS - 1)),
    .hold_last (3'(SLM_HOLD - 1)),
    .frame     (slm_frame)
  );

endmodule

// File: tb/tb_sprite_anim_sched.sv
// ---------------------------------------------------------------------------
// tb_sprite_anim_sched
// Directed bench for sprite_anim_sched with TICK_DIV=10. Every input change
// goes through applyStimulus (one clock per call, outputs sampled 1 time
// unit after the rising edge) and every comparison through checkOutput.
// Edge numbering in the comments counts rising edges after the last reset
// edge (E0); animation ticks therefore land on edges E10, E20, ...
// ---------------------------------------------------------------------------
module tb_sprite_anim_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vs = 1'b1;
  logic [1:0] mode_req = 2'd0;
  logic       mode_req_valid = 1'b0;
  logic       mode_req_ready;
  logic [1:0] ply_mode;
  logic [3:0] ply_frame;
  logic [3:0] slm_frame;
  logic       frame_strobe;
  logic       mode_err;
`ifdef SPRITE_ANIM_FREEZE_EN
  logic       freeze = 1'b0;
`endif

  int checks_done = 0;
  int checks_passed = 0;

  sprite_anim_sched #(.TICK_DIV(10)) dut (
    .clk            (clk),
    .rst            (rst),
`ifdef SPRITE_ANIM_FREEZE_EN
    .freeze         (freeze),
`endif
    .vs             (vs),
    .mode_req       (mode_req),
    .mode_req_valid (mode_req_valid),
    .mode_req_ready (mode_req_ready),
    .ply_mode       (ply_mode),
    .ply_frame      (ply_frame),
    .slm_frame      (slm_frame),
    .frame_strobe   (frame_strobe),
    .mode_err       (mode_err)
  );

  always #5 clk = ~clk;

  // Drive one clock cycle worth of inputs, then return to idle levels
  task automatic applyStimulus(input logic rst_v, input logic vs_v,
                               input logic req_v, input logic [1:0] req);
    rst            = rst_v;
    vs             = vs_v;
    mode_req_valid = req_v;
    mode_req       = req;
    @(posedge clk);
    #1;
    rst            = 1'b0;
    vs             = 1'b1;
    mode_req_valid = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
  endtask

  // n edges in total; the last one is the vsync boundary
  task automatic boundaryAfter(input int n, input logic req_v,
                               input logic [1:0] req);
    waitCycles(n - 1);
    applyStimulus(1'b0, 1'b0, req_v, req);
  endtask

  task automatic checkOutput(input string tag, input int actual,
                             input int expected);
    checks_done++;
    if (actual == expected) checks_passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
  endtask

  initial begin
    // Reset: second reset edge is E0
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0);
    checkOutput("rst_ply_mode", ply_mode, 0);
    checkOutput("rst_ply_frame", ply_frame, 0);
    checkOutput("rst_slm_frame", slm_frame, 0);
    checkOutput("rst_strobe", frame_strobe, 0);
    checkOutput("rst_mode_err", mode_err, 0);
    checkOutput("rst_ready", mode_req_ready, 1);

    // E5: boundary before any tick, nothing advances
    boundaryAfter(5, 1'b0, 2'd0);
    checkOutput("b1_strobe", frame_strobe, 1);
    checkOutput("b1_slm", slm_frame, 0);
    waitCycles(1);
    checkOutput("b1_strobe_off", frame_strobe, 0);
    // E55, E105, E155, E205 each carry a tick
    boundaryAfter(49, 1'b0, 2'd0);
    checkOutput("b2_slm", slm_frame, 0);
    checkOutput("b2_ply", ply_frame, 0);
    boundaryAfter(50, 1'b0, 2'd0);
    checkOutput("b3_slm", slm_frame, 1);
    checkOutput("b3_ply", ply_frame, 0);
    boundaryAfter(50, 1'b0, 2'd0);
    checkOutput("b4_slm", slm_frame, 1);
    checkOutput("b4_ply", ply_frame, 0);
    boundaryAfter(50, 1'b0, 2'd0);
    checkOutput("b5_slm", slm_frame, 2);
    checkOutput("b5_ply", ply_frame, 1);
    checkOutput("b5_strobe", frame_strobe, 1);

    // RUN_R request mid-frame at E216, applied at E255
    waitCycles(10);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd1);
    checkOutput("req_ready_low", mode_req_ready, 0);
    checkOutput("req_mode_held", ply_mode, 0);
    boundaryAfter(39, 1'b0, 2'd0);
    checkOutput("run_mode", ply_mode, 1);
    checkOutput("run_frame0", ply_frame, 0);
    checkOutput("run_ready", mode_req_ready, 1);
    checkOutput("run_slm", slm_frame, 2);

    // 16 more boundaries: run frame steps every 2 ticks and wraps 7 -> 0
    for (int k = 1; k <= 16; k++) begin
      boundaryAfter(50, 1'b0, 2'd0);
      checkOutput("run_ply_seq", ply_frame, (k / 2) % 8);
      checkOutput("run_slm_seq", slm_frame, 2 + (k + 1) / 2);
    end

    // vs period 25 (E1080): several ticks collapse into one advance
    boundaryAfter(25, 1'b0, 2'd0);
    checkOutput("p25_ply", ply_frame, 0);
    checkOutput("p25_slm", slm_frame, 11);
    // E1090: only the terminal tick coinciding with the boundary
    boundaryAfter(10, 1'b0, 2'd0);
    checkOutput("tc_same_cycle_ply", ply_frame, 1);
    // E1095: no tick since, so nothing may advance
    boundaryAfter(5, 1'b0, 2'd0);
    checkOutput("no_tick_ply", ply_frame, 1);
    checkOutput("no_tick_slm", slm_frame, 11);
    boundaryAfter(25, 1'b0, 2'd0);
    checkOutput("p25b_ply", ply_frame, 1);
    checkOutput("p25b_slm", slm_frame, 12);
    boundaryAfter(25, 1'b0, 2'd0);
    checkOutput("p25c_ply", ply_frame, 2);

    // Illegal code 3 at E1146
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd3);
    checkOutput("ill_err", mode_err, 1);
    checkOutput("ill_ready", mode_req_ready, 1);
    waitCycles(1);
    checkOutput("ill_err_off", mode_err, 0);
    boundaryAfter(23, 1'b0, 2'd0);
    checkOutput("ill_mode", ply_mode, 1);
    checkOutput("ill_slm", slm_frame, 13);

    // IDLE request on the boundary cycle E1195 waits for E1220
    boundaryAfter(25, 1'b1, 2'd0);
    checkOutput("reqb_mode", ply_mode, 1);
    checkOutput("reqb_ply", ply_frame, 3);
    checkOutput("reqb_ready", mode_req_ready, 0);
    boundaryAfter(25, 1'b0, 2'd0);
    checkOutput("reqb_mode_next", ply_mode, 0);
    checkOutput("reqb_ply_next", ply_frame, 0);
    checkOutput("slm_wrap", slm_frame, 0);
    checkOutput("reqb_ready_next", mode_req_ready, 1);

    // Advance slime to 1 (E1270, E1320), then reset with RUN_R pending
    boundaryAfter(50, 1'b0, 2'd0);
    boundaryAfter(50, 1'b0, 2'd0);
    checkOutput("pre_rst_slm", slm_frame, 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd1);
    checkOutput("pre_rst_ready", mode_req_ready, 0);
    waitCycles(4);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0);
    checkOutput("mid_rst_slm", slm_frame, 0);
    checkOutput("mid_rst_mode", ply_mode, 0);
    checkOutput("mid_rst_ready", mode_req_ready, 1);
    boundaryAfter(5, 1'b0, 2'd0);
    checkOutput("lost_req_mode", ply_mode, 0);
    checkOutput("lost_req_strobe", frame_strobe, 1);

`ifdef SPRITE_ANIM_FREEZE_EN
    // Frozen over three boundaries; a RUN_R request still lands
    freeze = 1'b1;
    boundaryAfter(50, 1'b0, 2'd0);
    checkOutput("frz1_slm", slm_frame, 0);
    checkOutput("frz1_strobe", frame_strobe, 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd1);
    boundaryAfter(49, 1'b0, 2'd0);
    checkOutput("frz2_slm", slm_frame, 0);
    checkOutput("frz2_mode", ply_mode, 1);
    boundaryAfter(50, 1'b0, 2'd0);
    checkOutput("frz3_slm", slm_frame, 0);
    checkOutput("frz3_strobe", frame_strobe, 1);
    freeze = 1'b0;
    boundaryAfter(50, 1'b0, 2'd0);
    boundaryAfter(50, 1'b0, 2'd0);
    checkOutput("unfrz_slm", slm_frame, 1);
    checkOutput("unfrz_ply", ply_frame, 1);
`endif

    $display("%0d/%0d checks passed", checks_passed, checks_done);
    $finish;
  end

endmodule
